power_manager_n: RTL and testbench

POWER_MANAGER_N -- requirements
Module: power_manager_n

---
 rtl/pmu_pkg.sv | 35 +++
 rtl/pmu_domain_divider.sv | 56 +++++
 rtl/power_manager_n.sv | 126 ++++++++++++
 tb/tb_power_manager_n.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// Shared encodings, FSM state type and constants for the power manager.
package pmu_pkg;

  typedef enum logic [1:0] {
    LVL_FULL = 2'b00,
    LVL_HALF = 2'b01,
    LVL_SLOW = 2'b10,
    LVL_OFF  = 2'b11
  } level_e;

  typedef enum logic [1:0] {
    MODE_RESTORE   = 2'd0,
    MODE_ALL_OFF   = 2'd1,
    MODE_BOOT_IMG1 = 2'd2,
    MODE_BOOT_IMG2 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEL_HOLD = 2'd1,
    ST_BOOT     = 2'd2
  } state_e;

  localparam int unsigned SEL_HOLD_CYCLES = 2;

  function automatic logic [1:0] boot_sel_of(input mode_e m);
    return (m == MODE_BOOT_IMG1) ? 2'b01 : 2'b10;
  endfunction

  // Domain 0 must stay clocked, so an OFF request for it degrades to SLOW.
  function automatic level_e clamp_level(input level_e l, input logic is_dom0);
    return (is_dom0 && (l == LVL_OFF)) ? LVL_SLOW : l;
  endfunction

endpackage

// File: rtl/pmu_domain_divider.sv
// One power domain: level register plus divider producing registered clock-enable pulses.
// A load restarts the divider from 0; HALF wraps at 1, everything else at SLOW_DIV.
module pmu_domain_divider
  import pmu_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned SLOW_DIV    = 4999,
  parameter level_e      RESET_LEVEL = LVL_FULL
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  level_e load_level_i,
  output level_e level_o,
  output logic   en_o
);

  level_e               level_q, level_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, term;
  logic                 en_q, en_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    term    = (level_q == LVL_HALF) ? DIV_WIDTH'(1) : DIV_WIDTH'(SLOW_DIV);
    if (load_i) begin
      level_d = load_level_i;
      cnt_d   = '0;
      en_d    = (load_level_i == LVL_FULL);
    end else begin
      cnt_d = (cnt_q == term) ? '0 : cnt_q + DIV_WIDTH'(1);
      unique case (level_q)
        LVL_FULL:           en_d = 1'b1;
        LVL_HALF, LVL_SLOW: en_d = (cnt_q == term);
        default:            en_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  assign level_o = level_q;
  assign en_o    = en_q;

endmodule

// File: rtl/power_manager_n.sv
// Power manager: per-domain clock-enable levels, power modes and warmboot sequencing.
// Optional macro PMU_CMD_COUNT_EN enables the saturating cmd_count counter (tied to 0 otherwise).
module power_manager_n
  import pmu_pkg::*;
#(
  parameter int unsigned               NUM_DOMAINS  = 4,
  parameter int unsigned               DIV_WIDTH    = 16,
  parameter int unsigned               SLOW_DIV     = 4999,
  parameter logic [2*NUM_DOMAINS-1:0]  RESET_LEVELS = {2'b11, 2'b11, 2'b10, 2'b00}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [$clog2(NUM_DOMAINS)-1:0] cmd_domain,
  input  logic [1:0]                     cmd_level,
  input  logic                           mode_valid,
  input  logic [1:0]                     mode,
  output logic [NUM_DOMAINS-1:0]         domain_en,
  output logic [2*NUM_DOMAINS-1:0]       domain_level,
  output logic [1:0]                     boot_sel,
  output logic                           boot,
  output logic [7:0]                     cmd_count
);

  localparam int unsigned DW = $clog2(NUM_DOMAINS);
  localparam logic [1:0]  HOLD_LAST = 2'(SEL_HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] hold_q, hold_d;
  logic [1:0] boot_sel_q, boot_sel_d;
  mode_e      mode_s;
  logic       mode_exec, cmd_acc, mode_load;
  level_e     lvl [NUM_DOMAINS];

  assign mode_s = mode_e'(mode);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    boot_sel_d = boot_sel_q;
    cmd_ready  = (state_q == ST_IDLE) && !mode_valid;
    mode_exec  = (state_q == ST_IDLE) && mode_valid;
    cmd_acc    = cmd_valid && cmd_ready;
    mode_load  = mode_exec && ((mode_s == MODE_RESTORE) || (mode_s == MODE_ALL_OFF));
    unique case (state_q)
      ST_IDLE: begin
        if (mode_exec && ((mode_s == MODE_BOOT_IMG1) || (mode_s == MODE_BOOT_IMG2))) begin
          state_d    = ST_SEL_HOLD;
          hold_d     = '0;
          boot_sel_d = boot_sel_of(mode_s);
        end
      end
      ST_SEL_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_BOOT;
        else                     hold_d  = hold_q + 2'd1;
      end
      ST_BOOT: state_d = ST_BOOT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      boot_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      boot_sel_q <= boot_sel_d;
    end
  end

  assign boot     = (state_q == ST_BOOT);
  assign boot_sel = boot_sel_q;

  // Out-of-range domains match no IDX, so such commands are accepted but change nothing.
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
    localparam logic [DW-1:0] IDX     = DW'(i);
    localparam level_e        RST_LVL = level_e'(RESET_LEVELS[2*i +: 2]);
    logic   hit;
    level_e load_lvl;

    always_comb begin
      hit      = cmd_acc && (cmd_domain == IDX);
      load_lvl = clamp_level(level_e'(cmd_level), i == 0);
      if (mode_exec && (mode_s == MODE_RESTORE))      load_lvl = RST_LVL;
      else if (mode_exec && (mode_s == MODE_ALL_OFF)) load_lvl = (i == 0) ? lvl[i] : LVL_OFF;
    end

    pmu_domain_divider #(
      .DIV_WIDTH  (DIV_WIDTH),
      .SLOW_DIV   (SLOW_DIV),
      .RESET_LEVEL(RST_LVL)
    ) u_div (
      .clk         (clk),
      .reset       (reset),
      .load_i      (hit || mode_load),
      .load_level_i(load_lvl),
      .level_o     (lvl[i]),
      .en_o        (domain_en[i])
    );

    assign domain_level[2*i +: 2] = lvl[i];
  end

`ifdef PMU_CMD_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if ((cmd_acc || mode_exec) && (count_q != 8'hFF)) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign cmd_count = count_q;
`else
  assign cmd_count = '0;
`endif

endmodule

// File: tb/tb_power_manager_n.sv
// Scoreboard bench for power_manager_n: a cycles-since-load reference model pushes expected outputs per edge.
module tb_power_manager_n;

  localparam int ND = 4;
  localparam int SD = 4999;
  localparam logic [7:0] RL = {2'b11, 2'b11, 2'b10, 2'b00};

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_ready, mode_valid, boot;
  logic [1:0] cmd_domain, cmd_level, mode, boot_sel;
  logic [3:0] domain_en;
  logic [7:0] domain_level, cmd_count;

  always #5 clk = ~clk;

  power_manager_n #(
    .NUM_DOMAINS (ND),
    .DIV_WIDTH   (16),
    .SLOW_DIV    (SD),
    .RESET_LEVELS(RL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_domain  (cmd_domain),
    .cmd_level   (cmd_level),
    .mode_valid  (mode_valid),
    .mode        (mode),
    .domain_en   (domain_en),
    .domain_level(domain_level),
    .boot_sel    (boot_sel),
    .boot        (boot),
    .cmd_count   (cmd_count)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [7:0] lvl;
    logic       rdy;
    logic       boot;
    logic [1:0] sel;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] rl_v;
  logic [1:0] m_lvl [ND];
  int         m_ph  [ND];
  int         m_st, m_h, m_cnt;
  logic [1:0] m_sel;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rl_v = RL;
    for (int d = 0; d < ND; d++) begin
      m_lvl[d] = rl_v[2*d +: 2];
      m_ph[d]  = 0;
    end
    m_st  = 0;
    m_h   = 0;
    m_sel = 2'b00;
    m_cnt = 0;
  endtask

  // Advances the model across one clock edge using the inputs currently driven.
  task automatic model_step(output exp_t e);
    bit idle, exec, acc, ld;
    idle = (m_st == 0);
    exec = idle && mode_valid;
    acc  = idle && !mode_valid && cmd_valid;
    e    = '0;
    for (int d = 0; d < ND; d++) begin
      ld = 1'b0;
      if (exec && mode == 2'd0) begin
        m_lvl[d] = rl_v[2*d +: 2];
        ld = 1'b1;
      end else if (exec && mode == 2'd1) begin
        if (d != 0) m_lvl[d] = 2'b11;
        ld = 1'b1;
      end else if (acc && int'(cmd_domain) == d) begin
        m_lvl[d] = (d == 0 && cmd_level == 2'b11) ? 2'b10 : cmd_level;
        ld = 1'b1;
      end
      m_ph[d] = ld ? 0 : m_ph[d] + 1;
      case (m_lvl[d])
        2'b00:   e.en[d] = 1'b1;
        2'b01:   e.en[d] = (m_ph[d] != 0) && (m_ph[d] % 2 == 0);
        2'b10:   e.en[d] = (m_ph[d] != 0) && (m_ph[d] % (SD + 1) == 0);
        default: e.en[d] = 1'b0;
      endcase
      e.lvl[2*d +: 2] = m_lvl[d];
    end
    if (m_st == 0) begin
      if (exec && mode[1]) begin
        m_st  = 1;
        m_h   = 1;
        m_sel = (mode == 2'd2) ? 2'b01 : 2'b10;
      end
    end else if (m_st == 1) begin
      if (m_h == 2) m_st = 2;
      else          m_h++;
    end
    if ((acc || exec) && m_cnt < 255) m_cnt++;
    e.rdy  = (m_st == 0) && !mode_valid;
    e.boot = (m_st == 2);
    e.sel  = m_sel;
`ifdef PMU_CMD_COUNT_EN
    e.cnt = 8'(m_cnt);
`else
    e.cnt = 8'd0;
`endif
  endtask

  task automatic cycle();
    exp_t e, o;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check_val("domain_en", 32'(domain_en), 32'(o.en));
    check_val("domain_level", 32'(domain_level), 32'(o.lvl));
    check_val("cmd_ready", 32'(cmd_ready), 32'(o.rdy));
    check_val("boot", 32'(boot), 32'(o.boot));
    check_val("boot_sel", 32'(boot_sel), 32'(o.sel));
    check_val("cmd_count", 32'(cmd_count), 32'(o.cnt));
  endtask

  task automatic idle(input int n);
    cmd_valid  = 1'b0;
    mode_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send_cmd(input logic [1:0] d, input logic [1:0] l);
    cmd_valid  = 1'b1;
    cmd_domain = d;
    cmd_level  = l;
    cycle();
    cmd_valid  = 1'b0;
  endtask

  task automatic send_mode(input logic [1:0] m, input logic cv);
    mode_valid = 1'b1;
    mode       = m;
    cmd_valid  = cv;
    cycle();
    mode_valid = 1'b0;
    cmd_valid  = 1'b0;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, then releases away from an edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_val({tag, "_boot"}, 32'(boot), 32'd0);
    check_val({tag, "_boot_sel"}, 32'(boot_sel), 32'd0);
    check_val({tag, "_en"}, 32'(domain_en), 32'd0);
    check_val({tag, "_level"}, 32'(domain_level), 32'(RL));
    check_val({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check_val({tag, "_count"}, 32'(cmd_count), 32'd0);
    @(posedge clk);
    #1;
    check_val({tag, "_en_held"}, 32'(domain_en), 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_domain = 2'd0;
    cmd_level  = 2'd0;
    mode_valid = 1'b0;
    mode       = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_en", 32'(domain_en), 32'd0);
    check_val("rst_level", 32'(domain_level), 32'(RL));
    check_val("rst_boot", 32'(boot), 32'd0);
    check_val("rst_boot_sel", 32'(boot_sel), 32'd0);
    check_val("rst_count", 32'(cmd_count), 32'd0);
    check_val("rst_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;

    // Default levels: dom0 every cycle, dom1 every 5000 cycles, dom2/3 silent.
    idle(10010);

    // HALF on domain 2: pulses at +2, +4, +6.
    send_cmd(2'd2, 2'b01);
    idle(8);
    check_val("half_level", 32'(domain_level[5:4]), 32'd1);

    // OFF on domain 0 degrades to SLOW.
    send_cmd(2'd0, 2'b11);
    check_val("dom0_slow", 32'(domain_level[1:0]), 32'd2);
    idle(5005);

    // Mixed traffic including modes 0/1 and modes colliding with commands.
    for (int k = 0; k < 200; k++) begin
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_domain = 2'($urandom_range(0, 3));
      cmd_level  = 2'($urandom_range(0, 3));
      mode_valid = ($urandom_range(0, 9) == 0);
      mode       = 2'($urandom_range(0, 1));
      cycle();
    end
    idle(4);

    // All-off then restore.
    send_mode(2'd1, 1'b0);
    check_val("alloff_level", 32'(domain_level[7:2]), 32'h3F);
    idle(6);
    send_mode(2'd0, 1'b1);
    check_val("restore_level", 32'(domain_level), 32'(RL));
    idle(6);

    // 300 back-to-back commands saturate the counter when enabled.
    for (int k = 0; k < 300; k++) begin
      cmd_valid  = 1'b1;
      cmd_domain = 2'($urandom_range(0, 3));
      cmd_level  = 2'($urandom_range(0, 3));
      cycle();
    end
    idle(3);
`ifdef PMU_CMD_COUNT_EN
    check_val("count_sat", 32'(cmd_count), 32'd255);
`else
    check_val("count_tied", 32'(cmd_count), 32'd0);
`endif

    // Warmboot to image 1 with a colliding command; later requests are ignored.
    send_mode(2'd2, 1'b1);
    check_val("boot_sel_e1", 32'(boot_sel), 32'd1);
    idle(1);
    check_val("boot_e2", 32'(boot), 32'd0);
    idle(1);
    check_val("boot_e3", 32'(boot), 32'd1);
    send_mode(2'd0, 1'b0);
    send_mode(2'd3, 1'b1);
    send_cmd(2'd1, 2'b00);
    idle(5);
    async_reset("rst_in_boot");
    idle(4);

    // Warmboot to image 2, reset while in SEL_HOLD.
    send_mode(2'd3, 1'b0);
    check_val("boot_sel_img2", 32'(boot_sel), 32'd2);
    idle(1);
    async_reset("rst_in_hold");
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
